// File: rtl/sld_stream_pkg.sv
// Shared definitions for the byte-stream sequencer.
//   - state_e           : 3-bit FSM encoding
//   - DefStartDelay     : default cycles from accepted start to first fetch
//   - DefGapCycles      : default idle cycles between bytes
//   - CLK_PER_HALF_BIT  : UART half-bit period in clocks used by the loader harness
//   - timer_width()     : counter width needed to hold the larger of two delays
package sld_stream_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle      = 3'd0,
    StWaitStart = 3'd1,
    StFetch     = 3'd2,
    StLoad      = 3'd3,
    StSend      = 3'd4,
    StGap       = 3'd5,
    StDone      = 3'd6
  } state_e;

  localparam int unsigned DefStartDelay  = 70000;
  localparam int unsigned DefGapCycles   = 500;
  localparam int unsigned CLK_PER_HALF_BIT = 435;

  // Timer is loaded with (delay - 1), so it must hold max(a, b) - 1.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter shared by the start-delay and inter-byte gap phases.
//   clk, rstn    : clock, synchronous active-low reset
//   load_i       : load load_val_i this cycle (has priority over en_i)
//   load_val_i   : value to load
//   en_i         : decrement by one while non-zero
//   zero_o       : counter currently equals zero
module interval_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sld_stream_ctrl.sv
// Streams len bytes from a 1-cycle-latency byte memory into a UART transmitter over
// valid/ready, with a start delay before the first fetch and an idle gap after each byte.
//   clk, rstn      : clock, synchronous active-low reset
//   start_i, len_i : begin a stream of len_i bytes (accepted only when idle)
//   abort_i        : stop request; a byte already offered is always completed first
//   mem_addr_o     : memory read address; mem_data_i returns one cycle later
//   tx_data_o, tx_valid_o, tx_ready_i : byte handshake to the transmitter
//   busy_o         : high outside idle
//   done_o         : one-cycle pulse when a stream ends (normal, aborted or empty)
//   sent_count_o   : bytes handshaken since the last accepted start
module sld_stream_ctrl
  import sld_stream_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned START_DELAY = DefStartDelay,
  parameter int unsigned GAP_CYCLES  = DefGapCycles
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] sent_count_o
);

  localparam int unsigned TimerW = timer_width(START_DELAY, GAP_CYCLES);
  localparam logic [TimerW-1:0] StartLoad = TimerW'(START_DELAY - 1);
  localparam logic [TimerW-1:0] GapLoad   = TimerW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] sent_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              abort_q;  // abort seen while a byte was pending in SEND

  logic              handshake;
  logic              tmr_load;
  logic [TimerW-1:0] tmr_val;
  logic              tmr_en;
  logic              tmr_zero;

  assign handshake = tx_valid_q && tx_ready_i;

  // Timer is reloaded on accepted start (start delay) and on each handshake (gap).
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = StartLoad;
    if ((state_q == StIdle) && start_i) begin
      tmr_load = 1'b1;
      tmr_val  = StartLoad;
    end else if ((state_q == StSend) && handshake) begin
      tmr_load = 1'b1;
      tmr_val  = GapLoad;
    end
  end

  assign tmr_en = (state_q == StWaitStart) || (state_q == StGap);

  interval_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      len_q      <= '0;
      addr_q     <= '0;
      sent_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          if (start_i) begin
            busy_q <= 1'b1;
            sent_q <= '0;
            if (len_i != '0) begin
              len_q   <= len_i;
              addr_q  <= '0;
              state_q <= StWaitStart;
            end else begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StWaitStart: begin
          if (abort_i) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (tmr_zero) begin
            state_q <= StFetch;
          end
        end
        StFetch: begin
          if (abort_i) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (abort_i) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            tx_data_q  <= mem_data_i;
            tx_valid_q <= 1'b1;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (handshake) begin
            tx_valid_q <= 1'b0;
            addr_q     <= addr_q + 1'b1;
            sent_q     <= sent_q + 1'b1;
            if ((sent_q + 1'b1 == len_q) || abort_q || abort_i) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (GAP_CYCLES == 0) begin
              state_q <= StFetch;
            end else begin
              state_q <= StGap;
            end
          end else if (abort_i) begin
            abort_q <= 1'b1;
          end
        end
        StGap: begin
          if (abort_i) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (tmr_zero) begin
            state_q <= StFetch;
          end
        end
        StDone: begin
          abort_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_addr_o   = addr_q;
  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign sent_count_o = sent_q;

endmodule

// File: tb/tb_sld_stream_ctrl.sv
// Directed bench for sld_stream_ctrl with START_DELAY=10, GAP_CYCLES=3, ADDR_W=8.
// ROM model: mem[i] = 0xA0 + i, one cycle read latency.
module tb_sld_stream_ctrl;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] len = '0;
  logic          abort = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] sent_count;

  int n_vec = 0;
  int n_err = 0;

  sld_stream_ctrl #(
    .ADDR_W      (AW),
    .START_DELAY (10),
    .GAP_CYCLES  (3)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start),
    .len_i        (len),
    .abort_i      (abort),
    .mem_addr_o   (mem_addr),
    .mem_data_i   (mem_data),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .busy_o       (busy),
    .done_o       (done),
    .sent_count_o (sent_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= 8'hA0 + mem_addr;

  // Event log taken at each rising edge (values before that edge's update).
  int         cyc = 0;
  int         start_cyc = 0;
  logic [7:0] hs_q[$];
  int         hsc_q[$];
  int         rise_q[$];
  int         done_cnt = 0;
  logic       prev_valid = 1'b0;

  always @(posedge clk) begin
    if (start && !busy && rstn) start_cyc = cyc;
    if (tx_valid && tx_ready) begin
      hs_q.push_back(tx_data);
      hsc_q.push_back(cyc);
    end
    if (tx_valid && !prev_valid) rise_q.push_back(cyc);
    prev_valid = tx_valid;
    if (done) done_cnt++;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hs_at(input int i);
    return (i < hs_q.size()) ? {24'h0, hs_q[i]} : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] hsc_at(input int i);
    return (i < hsc_q.size()) ? hsc_q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic clear_log();
    hs_q.delete();
    hsc_q.delete();
    rise_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] l);
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit hit);
    int n;
    hit = 1'b0;
    n = 0;
    while (!hit && n < max_cyc) begin
      @(negedge clk);
      if (done === 1'b1) hit = 1'b1;
      n++;
    end
  endtask

  task automatic wait_valid(input int max_cyc, output bit hit);
    int n;
    hit = 1'b0;
    n = 0;
    while (!hit && n < max_cyc) begin
      @(negedge clk);
      if (tx_valid === 1'b1) hit = 1'b1;
      n++;
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   hit;
    logic stable;
    logic [31:0] cnt_snap;

    @(negedge clk);
    apply_reset();
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_txdata", 32'(tx_data), 32'h0);
    check("rst_valid", 32'(tx_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sent", 32'(sent_count), 32'h0);

    // 1: len=3, ready tied high.
    tx_ready = 1'b1;
    clear_log();
    pulse_start(8'd3);
    wait_done(200, hit);
    check("t1_done_seen", 32'(hit), 32'h1);
    check("t1_busy_with_done", 32'(busy), 32'h1);
    @(negedge clk);
    check("t1_busy_falls", 32'(busy), 32'h0);
    check("t1_done_falls", 32'(done), 32'h0);
    check("t1_hs_count", hs_q.size(), 32'd3);
    check("t1_byte0", hs_at(0), 32'hA0);
    check("t1_byte1", hs_at(1), 32'hA1);
    check("t1_byte2", hs_at(2), 32'hA2);
    // tx_valid registered 12 edges after start; the log sees it one edge later.
    check("t1_first_valid", (rise_q.size() > 0) ? rise_q[0] - start_cyc : -1, 32'd13);
    // Handshakes are 6 edges apart: 5 non-handshake cycles in between.
    check("t1_hs_gap01", hsc_at(1) - hsc_at(0), 32'd6);
    check("t1_hs_gap12", hsc_at(2) - hsc_at(1), 32'd6);
    check("t1_done_count", done_cnt, 32'd1);
    check("t1_sent", 32'(sent_count), 32'd3);

    // 2: len=2, ready held low for 20 cycles once the first byte is offered.
    tx_ready = 1'b0;
    clear_log();
    pulse_start(8'd2);
    wait_valid(50, hit);
    check("t2_valid_seen", 32'(hit), 32'h1);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(tx_valid === 1'b1 && tx_data === 8'hA0)) stable = 1'b0;
    end
    check("t2_held_stable", 32'(stable), 32'h1);
    check("t2_no_hs_while_low", hs_q.size(), 32'd0);
    tx_ready = 1'b1;
    wait_done(100, hit);
    check("t2_done_seen", 32'(hit), 32'h1);
    check("t2_hs_count", hs_q.size(), 32'd2);
    check("t2_byte0", hs_at(0), 32'hA0);
    check("t2_byte1", hs_at(1), 32'hA1);
    check("t2_sent", 32'(sent_count), 32'd2);

    // 3: len=0 from reset state.
    apply_reset();
    clear_log();
    pulse_start(8'd0);
    check("t3_done_next", 32'(done), 32'h1);
    check("t3_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    check("t3_done_once", 32'(done), 32'h0);
    repeat (20) @(negedge clk);
    check("t3_no_valid", rise_q.size(), 32'd0);
    check("t3_addr_after", 32'(mem_addr), 32'h0);
    check("t3_done_count", done_cnt, 32'd1);

    // 4: len=5, abort while SEND waits on ready.
    tx_ready = 1'b0;
    clear_log();
    pulse_start(8'd5);
    wait_valid(50, hit);
    check("t4_valid_seen", 32'(hit), 32'h1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_valid_kept", 32'(tx_valid), 32'h1);
    check("t4_no_done_yet", done_cnt, 32'd0);
    tx_ready = 1'b1;
    wait_done(20, hit);
    check("t4_done_seen", 32'(hit), 32'h1);
    repeat (20) @(negedge clk);
    check("t4_hs_count", hs_q.size(), 32'd1);
    check("t4_byte0", hs_at(0), 32'hA0);
    check("t4_sent", 32'(sent_count), 32'd1);
    check("t4_addr", 32'(mem_addr), 32'd1);
    check("t4_valid_off", 32'(tx_valid), 32'h0);

    // 5: len=4 with a second start mid-stream.
    clear_log();
    pulse_start(8'd4);
    repeat (20) @(negedge clk);
    pulse_start(8'd7);
    wait_done(200, hit);
    check("t5_done_seen", 32'(hit), 32'h1);
    repeat (5) @(negedge clk);
    check("t5_hs_count", hs_q.size(), 32'd4);
    check("t5_byte3", hs_at(3), 32'hA3);
    check("t5_sent", 32'(sent_count), 32'd4);
    check("t5_done_count", done_cnt, 32'd1);

    // 6: reset in GAP after two bytes, then a fresh stream.
    clear_log();
    pulse_start(8'd5);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!hit) begin
        @(negedge clk);
        if (hs_q.size() == 2) hit = 1'b1;
      end
    end
    check("t6_two_bytes", 32'(hit), 32'h1);
    cnt_snap = 32'(sent_count);
    check("t6_sent_before_rst", cnt_snap, 32'd2);
    rstn = 1'b0;
    @(negedge clk);
    check("t6_rst_addr", 32'(mem_addr), 32'h0);
    check("t6_rst_txdata", 32'(tx_data), 32'h0);
    check("t6_rst_valid", 32'(tx_valid), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_done", 32'(done), 32'h0);
    check("t6_rst_sent", 32'(sent_count), 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    clear_log();
    pulse_start(8'd1);
    wait_done(100, hit);
    check("t6_done_seen", 32'(hit), 32'h1);
    check("t6_first_byte", hs_at(0), 32'hA0);
    check("t6_sent", 32'(sent_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
